// File: rtl/myproject_mac_pipe_ce_if.sv
// myproject_mac_pipe_ce_if: operand beat in, accumulated result out.
// master: drives beat, observes result. slave: the MAC side.
interface myproject_mac_pipe_ce_if #(
   parameter int DIN0_WIDTH = 16,
   parameter int DIN1_WIDTH = 8,
   parameter int ACC_WIDTH  = 32
);
   logic                  in_valid;
   logic [DIN0_WIDTH-1:0] din0;
   logic [DIN1_WIDTH-1:0] din1;
   logic                  acc_en;
   logic                  acc_clr;
   logic                  out_valid;
   logic [ACC_WIDTH-1:0]  dout;
   logic                  ovf;

   modport master (
      output in_valid, din0, din1, acc_en, acc_clr,
      input  out_valid, dout, ovf
   );

   modport slave (
      input  in_valid, din0, din1, acc_en, acc_clr,
      output out_valid, dout, ovf
   );
endinterface

// File: rtl/myproject_mac_pipe_ce.sv
// myproject_mac_pipe_ce: pipelined signed x unsigned MAC with clock enable.
// Ports: ap_clk, ap_rst_n (async low), ce, bus (beat in / dout, ovf out).
module myproject_mac_pipe_ce #(
   parameter int DIN0_WIDTH = 16,
   parameter int DIN1_WIDTH = 8,
   parameter int PROD_WIDTH = 24,
   parameter int ACC_WIDTH  = 32,
   parameter int NUM_STAGE  = 3,
   parameter int SATURATE   = 1
) (
   input  logic ap_clk,
   input  logic ap_rst_n,
   input  logic ce,
   myproject_mac_pipe_ce_if.slave bus
);

   typedef struct packed {
      logic                         vld;
      logic                         en;
      logic                         clr;
      logic signed [PROD_WIDTH-1:0] prod;
   } tap_t;

   localparam logic signed [ACC_WIDTH-1:0] ACC_MAX =
      {1'b0, {(ACC_WIDTH-1){1'b1}}};
   localparam logic signed [ACC_WIDTH-1:0] ACC_MIN =
      {1'b1, {(ACC_WIDTH-1){1'b0}}};

   // stage 1: input capture
   logic                  s1_vld_q, s1_vld_d;
   logic                  s1_en_q, s1_en_d;
   logic                  s1_clr_q, s1_clr_d;
   logic [DIN0_WIDTH-1:0] s1_a_q, s1_a_d;
   logic [DIN1_WIDTH-1:0] s1_b_q, s1_b_d;

   always_comb begin
      s1_vld_d = bus.in_valid;
      s1_en_d  = bus.acc_en;
      s1_clr_d = bus.acc_clr;
      s1_a_d   = bus.din0;
      s1_b_d   = bus.din1;
   end

   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         s1_vld_q <= 1'b0;
         s1_en_q  <= 1'b0;
         s1_clr_q <= 1'b0;
         s1_a_q   <= '0;
         s1_b_q   <= '0;
      end else if (ce) begin
         s1_vld_q <= s1_vld_d;
         s1_en_q  <= s1_en_d;
         s1_clr_q <= s1_clr_d;
         s1_a_q   <= s1_a_d;
         s1_b_q   <= s1_b_d;
      end
   end

   // din1 gets a zero MSB so it can never read as negative
   logic signed [PROD_WIDTH-1:0] a_ext;
   logic signed [PROD_WIDTH-1:0] b_ext;
   logic signed [PROD_WIDTH-1:0] prod;
   tap_t                         s1_tap;

   always_comb begin
      a_ext = PROD_WIDTH'($signed(s1_a_q));
      b_ext = PROD_WIDTH'({1'b0, s1_b_q});
      prod  = a_ext * b_ext;
      s1_tap      = '0;
      s1_tap.vld  = s1_vld_q;
      s1_tap.en   = s1_en_q;
      s1_tap.clr  = s1_clr_q;
      s1_tap.prod = prod;
   end

   // stages 2..NUM_STAGE-1: plain delay line
   tap_t fin;

   generate
      if (NUM_STAGE > 2) begin : g_dly
         localparam int DLY = NUM_STAGE - 2;
         tap_t dly_q [DLY];
         tap_t dly_d [DLY];

         always_comb begin
            dly_d[0] = s1_tap;
            for (int i = 1; i < DLY; i++) begin
               dly_d[i] = dly_q[i-1];
            end
         end

         always_ff @(posedge ap_clk or negedge ap_rst_n) begin
            if (!ap_rst_n) begin
               for (int i = 0; i < DLY; i++) begin
                  dly_q[i] <= '0;
               end
            end else if (ce) begin
               for (int i = 0; i < DLY; i++) begin
                  dly_q[i] <= dly_d[i];
               end
            end
         end

         assign fin = dly_q[DLY-1];
      end else begin : g_nodly
         assign fin = s1_tap;
      end
   endgenerate

   // final stage: accumulator doubles as the dout register
   logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
   logic                        out_vld_q, out_vld_d;
   logic                        ovf_q, ovf_d;
   logic signed [ACC_WIDTH-1:0] psx;
   logic [ACC_WIDTH:0]          sum;
   logic                        hit;
   logic                        run;

   always_comb begin
      psx = ACC_WIDTH'($signed(fin.prod));
      sum = {acc_q[ACC_WIDTH-1], acc_q}
          + {psx[ACC_WIDTH-1], psx};
      // sign bits disagree -> result left the ACC_WIDTH range
      hit = sum[ACC_WIDTH] ^ sum[ACC_WIDTH-1];
      run = fin.en & ~fin.clr;
      acc_d     = acc_q;
      ovf_d     = ovf_q;
      out_vld_d = 1'b0;
      unique case (1'b1)
         !fin.vld: begin
            out_vld_d = 1'b0;
         end
         fin.vld && run: begin
            out_vld_d = 1'b1;
            ovf_d     = ovf_q | hit;
            if (hit && (SATURATE != 0)) begin
               acc_d = sum[ACC_WIDTH] ? ACC_MIN : ACC_MAX;
            end else begin
               acc_d = sum[ACC_WIDTH-1:0];
            end
         end
         fin.vld && !run: begin
            out_vld_d = 1'b1;
            acc_d     = psx;
            ovf_d     = 1'b0;
         end
      endcase
   end

   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         acc_q     <= '0;
         out_vld_q <= 1'b0;
         ovf_q     <= 1'b0;
      end else if (ce) begin
         acc_q     <= acc_d;
         out_vld_q <= out_vld_d;
         ovf_q     <= ovf_d;
      end
   end

   assign bus.out_valid = out_vld_q;
   assign bus.dout      = acc_q;
   assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_myproject_mac_pipe_ce.sv
// tb_myproject_mac_pipe_ce: three MAC configurations on one stimulus
// stream, checked every cycle against a beat-history reference model.
module tb_myproject_mac_pipe_ce;

   logic ap_clk;
   logic ap_rst_n;
   logic ce;

   myproject_mac_pipe_ce_if #(.ACC_WIDTH(32)) if0 ();
   myproject_mac_pipe_ce_if #(.ACC_WIDTH(24)) if1 ();
   myproject_mac_pipe_ce_if #(.ACC_WIDTH(24)) if2 ();

   assign if1.in_valid = if0.in_valid;
   assign if1.din0     = if0.din0;
   assign if1.din1     = if0.din1;
   assign if1.acc_en   = if0.acc_en;
   assign if1.acc_clr  = if0.acc_clr;
   assign if2.in_valid = if0.in_valid;
   assign if2.din0     = if0.din0;
   assign if2.din1     = if0.din1;
   assign if2.acc_en   = if0.acc_en;
   assign if2.acc_clr  = if0.acc_clr;

   myproject_mac_pipe_ce #(
      .NUM_STAGE(3), .ACC_WIDTH(32), .SATURATE(1)
   ) u0 (
      .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .ce(ce), .bus(if0)
   );

   myproject_mac_pipe_ce #(
      .NUM_STAGE(2), .ACC_WIDTH(24), .SATURATE(1)
   ) u1 (
      .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .ce(ce), .bus(if1)
   );

   myproject_mac_pipe_ce #(
      .NUM_STAGE(5), .ACC_WIDTH(24), .SATURATE(0)
   ) u2 (
      .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .ce(ce), .bus(if2)
   );

   initial ap_clk = 1'b0;
   always #5 ap_clk = ~ap_clk;

   longint g_dout [3];
   bit     g_ov   [3];
   bit     g_ovf  [3];

   always_comb begin
      g_dout[0] = longint'($signed(if0.dout));
      g_dout[1] = longint'($signed(if1.dout));
      g_dout[2] = longint'($signed(if2.dout));
      g_ov[0]   = if0.out_valid;
      g_ov[1]   = if1.out_valid;
      g_ov[2]   = if2.out_valid;
      g_ovf[0]  = if0.ovf;
      g_ovf[1]  = if1.ovf;
      g_ovf[2]  = if2.ovf;
   end

   // reference model: every ce edge appends the sampled beat; a
   // configuration with NUM_STAGE n retires the beat n-1 edges back
   typedef struct {
      bit vld;
      bit en;
      bit clr;
      int a;
      int b;
   } beat_t;

   beat_t  hist [$];
   int     base;
   int     ns_c  [3] = '{3, 2, 5};
   int     aw_c  [3] = '{32, 24, 24};
   bit     sat_c [3] = '{1, 1, 0};
   longint m_acc [3];
   bit     m_ov  [3];
   bit     m_ovf [3];

   int n_chk;
   int n_err;

   task automatic chk(input string tag, input longint got,
                      input longint exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got %0d exp %0d", tag, got, exp);
      end
   endtask

   task automatic chk_all();
      for (int d = 0; d < 3; d++) begin
         chk($sformatf("d%0d_ov", d), longint'(g_ov[d]),
             longint'(m_ov[d]));
         chk($sformatf("d%0d_dout", d), g_dout[d], m_acc[d]);
         chk($sformatf("d%0d_ovf", d), longint'(g_ovf[d]),
             longint'(m_ovf[d]));
      end
   endtask

   task automatic model_clear();
      base = hist.size();
      for (int d = 0; d < 3; d++) begin
         m_acc[d] = 0;
         m_ov[d]  = 1'b0;
         m_ovf[d] = 1'b0;
      end
   endtask

   task automatic model_edge(input beat_t bt);
      int     idx;
      longint p;
      longint s;
      longint lim;
      hist.push_back(bt);
      for (int d = 0; d < 3; d++) begin
         idx = hist.size() - ns_c[d];
         m_ov[d] = 1'b0;
         if (idx >= base && hist[idx].vld) begin
            m_ov[d] = 1'b1;
            p = longint'(hist[idx].a) * longint'(hist[idx].b);
            if (!hist[idx].en || hist[idx].clr) begin
               m_acc[d] = p;
               m_ovf[d] = 1'b0;
            end else begin
               lim = longint'(1) <<< (aw_c[d] - 1);
               s = m_acc[d] + p;
               if (s >= lim || s < -lim) begin
                  m_ovf[d] = 1'b1;
                  if (sat_c[d]) begin
                     s = (s > 0) ? lim - 1 : -lim;
                  end else begin
                     s = s & (2 * lim - 1);
                     if (s >= lim) s = s - 2 * lim;
                  end
               end
               m_acc[d] = s;
            end
         end
      end
   endtask

   task automatic cyc(input bit c, input bit v, input bit e,
                      input bit cl, input int a, input int b);
      beat_t             bt;
      logic signed [15:0] a16;
      logic [7:0]         b8;
      a16 = 16'(a);
      b8  = 8'(b);
      ce           = c;
      if0.in_valid = v;
      if0.acc_en   = e;
      if0.acc_clr  = cl;
      if0.din0     = a16;
      if0.din1     = b8;
      bt.vld = v;
      bt.en  = e;
      bt.clr = cl;
      bt.a   = int'(a16);
      bt.b   = int'(b8);
      @(posedge ap_clk);
      if (c) model_edge(bt);
      #1;
      chk_all();
   endtask

   task automatic bub(input int n);
      for (int i = 0; i < n; i++) cyc(1, 0, 0, 0, 0, 0);
   endtask

   // reset lands between edges; outputs must clear with no edge
   task automatic async_rst();
      #2 ap_rst_n = 1'b0;
      #1;
      model_clear();
      chk_all();
      #2 ap_rst_n = 1'b1;
   endtask

   initial begin
      int a;
      int b;
      n_chk = 0;
      n_err = 0;
      base  = 0;
      ce    = 1'b0;
      ap_rst_n     = 1'b0;
      if0.in_valid = 1'b0;
      if0.acc_en   = 1'b0;
      if0.acc_clr  = 1'b0;
      if0.din0     = '0;
      if0.din1     = '0;
      model_clear();

      #3;
      chk_all();
      @(posedge ap_clk);
      #1;
      chk_all();
      #2 ap_rst_n = 1'b1;

      // plain product and latency
      cyc(1, 1, 0, 0, -3, 200);
      chk("t1_early1", g_ov[0], 0);
      bub(1);
      chk("t1_early2", g_ov[0], 0);
      bub(1);
      chk("t1_ov", g_ov[0], 1);
      chk("t1_dout", g_dout[0], -600);
      chk("t1_ovf", g_ovf[0], 0);
      bub(2);

      // signedness corners
      cyc(1, 1, 0, 0, -32768, 255);
      cyc(1, 1, 0, 0, 32767, 255);
      bub(1);
      chk("t2_neg", g_dout[0], -8355840);
      bub(1);
      chk("t2_pos", g_dout[0], 8355585);
      bub(3);

      // back-to-back accumulate, then across bubbles
      cyc(1, 1, 1, 1, 10, 3);
      cyc(1, 1, 1, 0, -4, 5);
      cyc(1, 1, 1, 0, 7, 2);
      chk("t3_s0", g_dout[0], 30);
      bub(1);
      chk("t3_s1", g_dout[0], 10);
      bub(1);
      chk("t3_s2", g_dout[0], 24);
      cyc(1, 1, 1, 0, 1, 1);
      chk("t3_bub0", g_ov[0], 0);
      bub(1);
      chk("t3_bub1", g_ov[0], 0);
      bub(1);
      chk("t3_ov", g_ov[0], 1);
      chk("t3_s3", g_dout[0], 25);
      bub(3);

      // ce freeze with beats in flight; junk on inputs is ignored
      cyc(1, 1, 1, 1, 5, 5);
      cyc(1, 1, 1, 0, 1, 2);
      cyc(1, 1, 1, 0, 1, 3);
      chk("t4_pre", g_dout[0], 25);
      for (int i = 0; i < 4; i++) begin
         cyc(0, 1, 1, 1, 9, 9);
         chk("t4_frz_ov", g_ov[0], 1);
         chk("t4_frz_dout", g_dout[0], 25);
      end
      bub(1);
      chk("t4_r1", g_dout[0], 27);
      bub(1);
      chk("t4_r2", g_dout[0], 30);
      bub(3);

      // saturation (u1) versus wrap (u2) at 24 bits
      cyc(1, 1, 1, 1, -32768, 255);
      cyc(1, 1, 1, 0, -32768, 255);
      chk("t5_sat_a", g_dout[1], -8355840);
      cyc(1, 1, 1, 1, 2, 2);
      chk("t5_sat_b", g_dout[1], -8388608);
      chk("t5_sat_ovf", g_ovf[1], 1);
      bub(1);
      chk("t5_sat_c", g_dout[1], 4);
      chk("t5_sat_clr", g_ovf[1], 0);
      bub(1);
      chk("t5_wr_a", g_dout[2], -8355840);
      bub(1);
      chk("t5_wr_b", g_dout[2], 65536);
      chk("t5_wr_ovf", g_ovf[2], 1);
      bub(1);
      chk("t5_wr_c", g_dout[2], 4);
      chk("t5_wr_clr", g_ovf[2], 0);
      bub(1);

      // asynchronous reset drops a pending sum
      cyc(1, 1, 1, 1, 100, 5);
      bub(2);
      chk("t6_pre", g_dout[0], 500);
      async_rst();
      chk("t6_rst_ov", g_ov[0], 0);
      chk("t6_rst_dout", g_dout[0], 0);
      chk("t6_rst_ovf", g_ovf[0], 0);
      cyc(1, 1, 1, 0, 2, 3);
      bub(2);
      chk("t6_post", g_dout[0], 6);
      bub(2);

      // randomized traffic
      for (int i = 0; i < 800; i++) begin
         if ($urandom_range(0, 3) == 0) begin
            a = ($urandom_range(0, 1) == 0) ? -32768 : 32767;
         end else begin
            a = int'($urandom_range(0, 65535));
         end
         if ($urandom_range(0, 2) == 0) begin
            b = 255;
         end else begin
            b = int'($urandom_range(0, 255));
         end
         if ($urandom_range(0, 119) == 0) begin
            async_rst();
         end
         cyc($urandom_range(0, 9) != 0,
             $urandom_range(0, 3) != 0,
             $urandom_range(0, 4) != 0,
             $urandom_range(0, 7) == 0,
             a, b);
      end

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
